// File: rtl/gpio_pkg.sv
// Shared defaults and edge-event helper for the debounced GPIO input block.
package gpio_pkg;

   localparam int GPIO_WIDTH       = 32;
   localparam int GPIO_SYNC_STAGES = 2;
   localparam int GPIO_PRE_W       = 16;
   localparam int GPIO_DB_W        = 4;

   typedef struct packed {
      logic rise;
      logic fall;
   } edge_evt_t;

   // Classifies an accepted debounce update by the direction of the change.
   function automatic edge_evt_t edge_event(input logic update,
                                            input logic old_val,
                                            input logic new_val);
      edge_evt_t evt;
      evt.rise = update & ~old_val & new_val;
      evt.fall = update & old_val & ~new_val;
      return evt;
   endfunction

endpackage

// File: rtl/gpio_db_ch.sv
// One input channel: synchroniser, polarity invert, tick-based debounce
// filter and sticky edge flag.
module gpio_db_ch
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
   parameter int DB_W        = GPIO_DB_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            gpio_i,
   input  logic            cfg_invert,
   input  logic            tick,
   input  logic [DB_W-1:0] cfg_db_ticks,
   input  logic            cfg_rise_en,
   input  logic            cfg_fall_en,
   input  logic            irq_clr,
   output logic            di_raw,
   output logic            di_status,
   output logic            edge_pending
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [DB_W-1:0]        cnt_q;
   logic [DB_W-1:0]        cnt_d;
   logic [DB_W:0]          cnt_inc;
   logic                   update;
   logic                   set_pending;
   edge_evt_t              evt;

   assign s       = sync_q[SYNC_STAGES-1] ^ cfg_invert;
   assign cnt_inc = {1'b0, cnt_q} + {{DB_W{1'b0}}, 1'b1};

   // A differing input must stay put for cfg_db_ticks ticks; the >= compare
   // keeps a count left over from a larger setting from getting stuck.
   always_comb begin
      update = 1'b0;
      cnt_d  = cnt_q;
      if (cfg_db_ticks == '0) begin
         update = (s != di_status);
         cnt_d  = '0;
      end else if (s == di_status) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_inc >= {1'b0, cfg_db_ticks}) begin
            update = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_inc[DB_W-1:0];
         end
      end
   end

   assign evt         = edge_event(update, di_status, s);
   assign set_pending = (evt.rise & cfg_rise_en) | (evt.fall & cfg_fall_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q       <= '0;
         di_raw       <= 1'b0;
         di_status    <= 1'b0;
         cnt_q        <= '0;
         edge_pending <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], gpio_i};
         di_raw       <= s;
         cnt_q        <= cnt_d;
         if (update) begin
            di_status <= s;
         end
         // A new edge outranks a simultaneous clear so no event is lost.
         edge_pending <= set_pending | (edge_pending & ~irq_clr);
      end
   end

endmodule

// File: rtl/gpio_input_db.sv
// Debounced PLC field-input block: shared prescaler, per-channel filters
// and a single masked edge interrupt.
module gpio_input_db
   import gpio_pkg::*;
#(
   parameter int WIDTH       = GPIO_WIDTH,
   parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
   parameter int PRE_W       = GPIO_PRE_W,
   parameter int DB_W        = GPIO_DB_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gpio_i,
   input  logic [WIDTH-1:0] cfg_invert,
   input  logic [PRE_W-1:0] cfg_prescale,
   input  logic [DB_W-1:0]  cfg_db_ticks,
   input  logic [WIDTH-1:0] cfg_rise_en,
   input  logic [WIDTH-1:0] cfg_fall_en,
   input  logic [WIDTH-1:0] cfg_irq_mask,
   input  logic [WIDTH-1:0] irq_clr,
   output logic [WIDTH-1:0] di_raw,
   output logic [WIDTH-1:0] di_status,
   output logic [WIDTH-1:0] edge_pending,
   output logic             irq
);

   logic [PRE_W-1:0] pre_q;
   logic             tick;

   // >= rather than == so lowering cfg_prescale below pre_q wraps at once.
   assign tick = (pre_q >= cfg_prescale);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         irq   <= 1'b0;
      end else begin
         pre_q <= tick ? '0 : pre_q + PRE_W'(1);
         irq   <= |(edge_pending & cfg_irq_mask);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      gpio_db_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_W        (DB_W)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .gpio_i       (gpio_i[i]),
         .cfg_invert   (cfg_invert[i]),
         .tick         (tick),
         .cfg_db_ticks (cfg_db_ticks),
         .cfg_rise_en  (cfg_rise_en[i]),
         .cfg_fall_en  (cfg_fall_en[i]),
         .irq_clr      (irq_clr[i]),
         .di_raw       (di_raw[i]),
         .di_status    (di_status[i]),
         .edge_pending (edge_pending[i])
      );
   end

endmodule

// File: tb/tb_gpio_input_db.sv
// Self-checking bench for gpio_input_db: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_gpio_input_db;
   import gpio_pkg::*;

   localparam int WIDTH = GPIO_WIDTH;
   localparam int SYNC  = GPIO_SYNC_STAGES;
   localparam int PRE_W = GPIO_PRE_W;
   localparam int DB_W  = GPIO_DB_W;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] gpio_i, cfg_invert, cfg_rise_en, cfg_fall_en;
   logic [WIDTH-1:0] cfg_irq_mask, irq_clr;
   logic [PRE_W-1:0] cfg_prescale;
   logic [DB_W-1:0]  cfg_db_ticks;
   logic [WIDTH-1:0] di_raw, di_status, edge_pending;
   logic             irq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gpio_input_db #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC),
      .PRE_W       (PRE_W),
      .DB_W        (DB_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .gpio_i       (gpio_i),
      .cfg_invert   (cfg_invert),
      .cfg_prescale (cfg_prescale),
      .cfg_db_ticks (cfg_db_ticks),
      .cfg_rise_en  (cfg_rise_en),
      .cfg_fall_en  (cfg_fall_en),
      .cfg_irq_mask (cfg_irq_mask),
      .irq_clr      (irq_clr),
      .di_raw       (di_raw),
      .di_status    (di_status),
      .edge_pending (edge_pending),
      .irq          (irq)
   );

   // Behavioural model: a delay line of raw samples, a tick counter and a
   // per-channel "how many ticks has the new value survived" count.
   logic [WIDTH-1:0] m_line [SYNC];
   logic [WIDTH-1:0] m_raw, m_status, m_pending;
   logic             m_irq;
   int               m_pre;
   int               m_cnt [WIDTH];

   always @(posedge clk) begin : model
      logic [WIDTH-1:0] s, prev;
      bit tick;
      if (rst) begin
         for (int k = 0; k < SYNC; k++) m_line[k] = '0;
         for (int c = 0; c < WIDTH; c++) m_cnt[c] = 0;
         m_raw = '0; m_status = '0; m_pending = '0; m_irq = 1'b0; m_pre = 0;
      end else begin
         s = m_line[SYNC-1] ^ cfg_invert;
         for (int k = SYNC-1; k > 0; k--) m_line[k] = m_line[k-1];
         m_line[0] = gpio_i;
         tick  = (m_pre >= int'(cfg_prescale));
         m_pre = tick ? 0 : m_pre + 1;
         m_irq = |(m_pending & cfg_irq_mask);
         prev  = m_status;
         for (int c = 0; c < WIDTH; c++) begin
            if (cfg_db_ticks == 0) begin
               m_status[c] = s[c];
               m_cnt[c]    = 0;
            end else if (s[c] == m_status[c]) begin
               m_cnt[c] = 0;
            end else if (tick) begin
               if (m_cnt[c] + 1 >= int'(cfg_db_ticks)) begin
                  m_status[c] = s[c];
                  m_cnt[c]    = 0;
               end else begin
                  m_cnt[c] = m_cnt[c] + 1;
               end
            end
         end
         m_pending = ((m_status & ~prev) & cfg_rise_en) |
                     ((~m_status & prev) & cfg_fall_en) |
                     (m_pending & ~irq_clr);
         m_raw = s;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      gpio_i = $urandom; cfg_invert = $urandom;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (di_raw !== '0) begin n_fail++; $display("[TB] FAIL reset_raw got=%h exp=0", di_raw); end
      n_checks++;
      if (di_status !== '0) begin n_fail++; $display("[TB] FAIL reset_status got=%h exp=0", di_status); end
      n_checks++;
      if (edge_pending !== '0) begin n_fail++; $display("[TB] FAIL reset_pending got=%h exp=0", edge_pending); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
      gpio_i = '0; cfg_invert = '0;
      rst = 1'b0;
   endtask

   task automatic test_bypass();
      cfg_db_ticks = '0; cfg_prescale = '0;
      cfg_rise_en = '1; cfg_fall_en = '1; cfg_irq_mask = 32'h1;
      do_reset();
      gpio_i[0] = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (di_status[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_early got=%b exp=0", di_status[0]); end
      @(negedge clk);
      n_checks++;
      if ({di_raw[0], di_status[0], edge_pending[0], irq} !== 4'b1110) begin
         n_fail++;
         $display("[TB] FAIL bypass_edge3 raw/status/pend/irq got=%b exp=1110",
                  {di_raw[0], di_status[0], edge_pending[0], irq});
      end
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_irq_edge4 got=%b exp=1", irq); end
   endtask

   task automatic test_debounce();
      int t_raw, t_stat;
      bit changed;
      cfg_db_ticks = 4'd4; cfg_prescale = 16'd9;
      cfg_rise_en = '1; cfg_fall_en = '1; cfg_irq_mask = '1;
      gpio_i = $urandom & ~32'h20;
      do_reset();
      gpio_i[5] = 1'b1;
      t_raw = -1; t_stat = -1;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         n_checks++;
         if ({di_raw, di_status, edge_pending, irq} !== {m_raw, m_status, m_pending, m_irq}) begin
            n_fail++;
            $display("[TB] FAIL debounce_model c=%0d got raw=%h st=%h pd=%h irq=%b exp raw=%h st=%h pd=%h irq=%b",
                     c, di_raw, di_status, edge_pending, irq, m_raw, m_status, m_pending, m_irq);
         end
         if (t_raw < 0 && di_raw[5]) t_raw = c;
         if (t_stat < 0 && di_status[5]) t_stat = c;
      end
      n_checks++;
      if (t_raw < 0 || t_stat < 0 || (t_stat - t_raw) < 30 || (t_stat - t_raw) > 50) begin
         n_fail++;
         $display("[TB] FAIL debounce_delay got raw@%0d status@%0d exp delay 30..50", t_raw, t_stat);
      end
      irq_clr = 32'h20;
      @(negedge clk);
      irq_clr = '0;
      changed = 1'b0;
      for (int c = 0; c < 100; c++) begin
         gpio_i[5] = (c < 25) ? 1'b0 : 1'b1;
         @(negedge clk);
         n_checks++;
         if ({di_raw, di_status, edge_pending, irq} !== {m_raw, m_status, m_pending, m_irq}) begin
            n_fail++;
            $display("[TB] FAIL glitch_model c=%0d got st=%h pd=%h exp st=%h pd=%h",
                     c, di_status, edge_pending, m_status, m_pending);
         end
         if (di_status[5] !== 1'b1 || edge_pending[5] !== 1'b0) changed = 1'b1;
      end
      n_checks++;
      if (changed) begin n_fail++; $display("[TB] FAIL glitch_filtered got change=1 exp change=0"); end
   endtask

   task automatic test_bounce();
      int t_last, t_stat;
      logic prev_raw;
      cfg_db_ticks = 4'd4; cfg_prescale = 16'd9;
      cfg_rise_en = '1; cfg_fall_en = '1; cfg_irq_mask = '1;
      gpio_i = '0;
      do_reset();
      t_last = -1; t_stat = -1; prev_raw = 1'b0;
      for (int c = 0; c < 130; c++) begin
         gpio_i[5] = (c < 30) ? 1'b1 : (c < 35) ? 1'b0 : 1'b1;
         @(negedge clk);
         n_checks++;
         if ({di_raw, di_status, edge_pending, irq} !== {m_raw, m_status, m_pending, m_irq}) begin
            n_fail++;
            $display("[TB] FAIL bounce_model c=%0d got raw=%h st=%h pd=%h exp raw=%h st=%h pd=%h",
                     c, di_raw, di_status, edge_pending, m_raw, m_status, m_pending);
         end
         if (di_raw[5] && !prev_raw) t_last = c;
         prev_raw = di_raw[5];
         if (t_stat < 0 && di_status[5]) t_stat = c;
      end
      n_checks++;
      if (t_last < 35 || t_stat <= t_last || (t_stat - t_last) < 30 || (t_stat - t_last) > 50) begin
         n_fail++;
         $display("[TB] FAIL bounce_restart got last_rise@%0d status@%0d exp status 30..50 after last rise",
                  t_last, t_stat);
      end
   endtask

   task automatic test_edge_select();
      cfg_db_ticks = '0; cfg_prescale = '0;
      cfg_rise_en = '0; cfg_fall_en = 32'h8; cfg_irq_mask = '0;
      gpio_i = '0;
      do_reset();
      gpio_i[3] = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++;
      if (edge_pending[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL select_no_rise got=%b exp=0", edge_pending[3]); end
      gpio_i[3] = 1'b0;
      repeat (6) @(negedge clk);
      n_checks++;
      if (edge_pending[3] !== 1'b1) begin n_fail++; $display("[TB] FAIL select_fall got=%b exp=1", edge_pending[3]); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL select_masked_irq got=%b exp=0", irq); end
      cfg_irq_mask[3] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL select_unmask_irq got=%b exp=1", irq); end
   endtask

   task automatic test_collision();
      cfg_db_ticks = '0; cfg_prescale = '0;
      cfg_rise_en = '1; cfg_fall_en = '1; cfg_irq_mask = 32'h4;
      gpio_i = '0;
      do_reset();
      gpio_i[2] = 1'b1;
      repeat (2) @(negedge clk);
      irq_clr[2] = 1'b1;
      @(negedge clk);
      irq_clr = '0;
      n_checks++;
      if (edge_pending[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL collision_set_wins got=%b exp=1", edge_pending[2]); end
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL collision_irq got=%b exp=1", irq); end
      irq_clr[2] = 1'b1;
      @(negedge clk);
      irq_clr = '0;
      n_checks++;
      if ({edge_pending[2], irq} !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL clear_alone pend/irq got=%b exp=01", {edge_pending[2], irq});
      end
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_irq_drop got=%b exp=0", irq); end
   endtask

   task automatic test_invert_reset();
      bit spurious;
      cfg_db_ticks = '0; cfg_prescale = '0;
      cfg_rise_en = '1; cfg_fall_en = '1; cfg_irq_mask = '1;
      gpio_i = '0; cfg_invert = '0;
      do_reset();
      cfg_invert[7] = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({di_status[7], edge_pending[7]} !== 2'b11) begin
         n_fail++;
         $display("[TB] FAIL invert_rise status/pend got=%b exp=11", {di_status[7], edge_pending[7]});
      end
      irq_clr = '1;
      cfg_db_ticks = 4'd4; cfg_prescale = 16'd9;
      gpio_i[7] = 1'b1;
      @(negedge clk);
      irq_clr = '0;
      repeat (15) @(negedge clk);
      n_checks++;
      if (di_status[7] !== 1'b1) begin n_fail++; $display("[TB] FAIL invert_counting got=%b exp=1", di_status[7]); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({di_raw, di_status, edge_pending, irq} !== '0) begin
         n_fail++;
         $display("[TB] FAIL midop_reset got raw=%h st=%h pd=%h irq=%b exp all 0",
                  di_raw, di_status, edge_pending, irq);
      end
      spurious = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         n_checks++;
         if ({di_raw, di_status, edge_pending, irq} !== {m_raw, m_status, m_pending, m_irq}) begin
            n_fail++;
            $display("[TB] FAIL post_reset_model c=%0d got raw=%h st=%h pd=%h exp raw=%h st=%h pd=%h",
                     c, di_raw, di_status, edge_pending, m_raw, m_status, m_pending);
         end
         if (edge_pending !== '0 || di_status !== '0) spurious = 1'b1;
      end
      n_checks++;
      if (spurious) begin n_fail++; $display("[TB] FAIL post_reset_spurious got=1 exp=0"); end
      cfg_invert = '0;
   endtask

   task automatic test_random();
      cfg_invert   = $urandom;
      cfg_prescale = PRE_W'($urandom_range(0, 4));
      cfg_db_ticks = DB_W'($urandom_range(0, 4));
      cfg_rise_en  = $urandom;
      cfg_fall_en  = $urandom;
      cfg_irq_mask = $urandom;
      gpio_i       = $urandom;
      do_reset();
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         n_checks++;
         if ({di_raw, di_status, edge_pending, irq} !== {m_raw, m_status, m_pending, m_irq}) begin
            n_fail++;
            $display("[TB] FAIL random_model c=%0d got raw=%h st=%h pd=%h irq=%b exp raw=%h st=%h pd=%h irq=%b",
                     c, di_raw, di_status, edge_pending, irq, m_raw, m_status, m_pending, m_irq);
         end
         gpio_i  = gpio_i ^ ($urandom & $urandom & $urandom & $urandom);
         irq_clr = $urandom & $urandom & $urandom;
         if (c % 200 == 199) begin
            cfg_prescale = PRE_W'($urandom_range(0, 4));
            cfg_db_ticks = DB_W'($urandom_range(0, 5));
            cfg_irq_mask = $urandom;
         end
      end
      irq_clr = '0;
   endtask

   initial begin
      rst = 1'b1;
      gpio_i = '0; cfg_invert = '0; cfg_prescale = '0; cfg_db_ticks = '0;
      cfg_rise_en = '0; cfg_fall_en = '0; cfg_irq_mask = '0; irq_clr = '0;
      @(negedge clk);
      $display("[TB] starting gpio_input_db tests");
      test_reset();
      test_bypass();
      test_debounce();
      test_bounce();
      test_edge_select();
      test_collision();
      test_invert_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
